// File: rtl/opmem_pkg.sv
// Shared definitions for the memory-operation controller: opcode codes,
// datapath operand-select codes, FSM state encoding and the Moore output
// decode used by controle_operacao_memoria.
package opmem_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LDUR = 2'b10,
    OP_STUR = 2'b11
  } opcode_t;

  // Operand select: registers A,B or register A plus immediate offset
  localparam logic [1:0] SEL_A_B      = 2'b00;
  localparam logic [1:0] SEL_A_OFFSET = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_FIM  = 3'd4,
    ST_ERRO = 3'd5
  } estado_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] op_mem_i;
    logic       add_sub;
    logic       rf_we;
    logic       rf_wsel;
    logic       mem_req;
    logic       mem_we;
  } controle_t;

  // Control word for a given state and latched opcode. WB keeps the
  // datapath selection of EXEC so the written ALU result stays stable.
  function automatic controle_t decodifica(estado_t estado, opcode_t op);
    controle_t c;
    c = '0;
    case (estado)
      ST_IDLE: begin
        c = '0;
      end
      ST_EXEC: begin
        c.busy     = 1'b1;
        c.op_mem_i = (op == OP_LDUR || op == OP_STUR) ? SEL_A_OFFSET : SEL_A_B;
        c.add_sub  = (op == OP_SUB);
      end
      ST_MEM: begin
        c.busy     = 1'b1;
        c.mem_req  = 1'b1;
        c.mem_we   = (op == OP_STUR);
        c.op_mem_i = SEL_A_OFFSET;
      end
      ST_WB: begin
        c.busy     = 1'b1;
        c.rf_we    = 1'b1;
        c.rf_wsel  = (op == OP_LDUR);
        c.op_mem_i = (op == OP_LDUR) ? SEL_A_OFFSET : SEL_A_B;
        c.add_sub  = (op == OP_SUB);
      end
      ST_FIM: begin
        c.done = 1'b1;
      end
      ST_ERRO: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// MEM-wait counter: counts cycles spent in MEM without an acknowledge.
// 'expired' is high during the TIMEOUT_CYC-th consecutive waiting cycle.
module contador_timeout #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CYC - 1);

  logic [7:0] conta_r;
  logic       expirou_r;

  // Count waiting cycles and flag the last one allowed before timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conta_r   <= 8'd0;
      expirou_r <= 1'b0;
    end else if (clear) begin
      conta_r   <= 8'd0;
      expirou_r <= 1'b0;
    end else if (enable) begin
      conta_r   <= conta_r + 8'd1;
      expirou_r <= ((conta_r + 8'd1) == LIMITE);
    end else begin
      conta_r   <= conta_r;
      expirou_r <= expirou_r;
    end
  end

  assign expired = expirou_r;

endmodule

// File: rtl/controle_operacao_memoria.sv
// Control FSM for ALU (ADD/SUB) and memory (LDUR/STUR) instructions with a
// bounded wait on the memory acknowledge. Optional macro FLAGS_REG_EN adds
// a register holding the ALU flags of the last ADD/SUB.
module controle_operacao_memoria
  import opmem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] opcode,
  output logic       busy,
  output logic       done,
  output logic [1:0] op_mem_i,
  output logic       add_sub,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ack,
  input  logic [5:0] flags_in,
  output logic [5:0] flags_q,
  output logic       erro
);

  estado_t   estado_r;
  estado_t   estado_nxt_s;
  opcode_t   opcode_r;
  opcode_t   opcode_nxt_s;
  controle_t ctrl_r;
  logic      erro_r;
  logic      expirou_s;
  logic      limpa_s;
  logic      conta_s;
  logic      aceita_s;

  assign aceita_s = (estado_r == ST_IDLE) && start;
  assign limpa_s  = (estado_r != ST_MEM);
  assign conta_s  = (estado_r == ST_MEM) && !mem_ack;

  contador_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_contador_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (limpa_s),
    .enable  (conta_s),
    .expired (expirou_s)
  );

  // Next-state and opcode-latch decision; an ack on the last timeout cycle wins
  always_comb begin
    estado_nxt_s = estado_r;
    opcode_nxt_s = opcode_r;
    case (estado_r)
      ST_IDLE: begin
        if (start) begin
          estado_nxt_s = ST_EXEC;
          opcode_nxt_s = opcode_t'(opcode);
        end else begin
          estado_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (opcode_r == OP_LDUR || opcode_r == OP_STUR) begin
          estado_nxt_s = ST_MEM;
        end else begin
          estado_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (opcode_r == OP_STUR) begin
            estado_nxt_s = ST_FIM;
          end else begin
            estado_nxt_s = ST_WB;
          end
        end else if (expirou_s) begin
          estado_nxt_s = ST_ERRO;
        end else begin
          estado_nxt_s = ST_MEM;
        end
      end
      ST_WB:   estado_nxt_s = ST_FIM;
      ST_FIM:  estado_nxt_s = ST_IDLE;
      ST_ERRO: estado_nxt_s = ST_IDLE;
      default: estado_nxt_s = ST_IDLE;
    endcase
  end

  // State register with outputs registered alongside it from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= ST_IDLE;
      opcode_r <= OP_ADD;
      ctrl_r   <= '0;
      erro_r   <= 1'b0;
    end else begin
      estado_r <= estado_nxt_s;
      opcode_r <= opcode_nxt_s;
      ctrl_r   <= decodifica(estado_nxt_s, opcode_nxt_s);
      if (aceita_s) begin
        erro_r <= 1'b0;
      end else if (estado_nxt_s == ST_ERRO) begin
        erro_r <= 1'b1;
      end else begin
        erro_r <= erro_r;
      end
    end
  end

`ifdef FLAGS_REG_EN
  logic [5:0] flags_r;

  // Capture ALU flags while an ADD/SUB is executing, hold them otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 6'h00;
    end else if (estado_r == ST_EXEC && (opcode_r == OP_ADD || opcode_r == OP_SUB)) begin
      flags_r <= flags_in;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign flags_q = flags_r;
`else
  logic unused_flags_s;
  assign unused_flags_s = ^flags_in;
  assign flags_q        = 6'h00;
`endif

  assign busy     = ctrl_r.busy;
  assign done     = ctrl_r.done;
  assign op_mem_i = ctrl_r.op_mem_i;
  assign add_sub  = ctrl_r.add_sub;
  assign rf_we    = ctrl_r.rf_we;
  assign rf_wsel  = ctrl_r.rf_wsel;
  assign mem_req  = ctrl_r.mem_req;
  assign mem_we   = ctrl_r.mem_we;
  assign erro     = erro_r;

endmodule

// File: tb/tb_controle_operacao_memoria.sv
// Self-checking bench for controle_operacao_memoria (TIMEOUT_CYC = 4).
// Directed table, hand sequences for reset and ignored start, and random
// transactions checked cycle by cycle against a timeline model.
module tb_controle_operacao_memoria;

  localparam int T = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] opcode;
  logic       busy;
  logic       done;
  logic [1:0] op_mem_i;
  logic       add_sub;
  logic       rf_we;
  logic       rf_wsel;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic [5:0] flags_in;
  logic [5:0] flags_q;
  logic       erro;

  int n_assert = 0;
  int n_fail   = 0;

  logic       erro_mod;
  logic [5:0] flags_mod;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] op_mem_i;
    logic       add_sub;
    logic       rf_we;
    logic       rf_wsel;
    logic       mem_req;
    logic       mem_we;
    logic       erro;
    logic [5:0] flags;
  } saida_t;

  typedef struct {
    logic [1:0] op;
    int         w;
    logic [5:0] fl;
    int         done_exp;
    int         req_exp;
    int         we_exp;
    logic       erro_exp;
  } vetor_t;

  controle_operacao_memoria #(.TIMEOUT_CYC(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .busy     (busy),
    .done     (done),
    .op_mem_i (op_mem_i),
    .add_sub  (add_sub),
    .rf_we    (rf_we),
    .rf_wsel  (rf_wsel),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .flags_in (flags_in),
    .flags_q  (flags_q),
    .erro     (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_assert++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  function automatic saida_t atual_s();
    saida_t a;
    a = {busy, done, op_mem_i, add_sub, rf_we, rf_wsel, mem_req, mem_we, erro, flags_q};
    return a;
  endfunction

  // Number of MEM cycles (acked or timed out); 0 for ALU ops
  function automatic int ciclos_mem(input logic [1:0] op, input int w);
    if (op < 2'd2) return 0;
    return (w >= T) ? T : w + 1;
  endfunction

  // Cycle (after start sampled on cycle 0) holding done
  function automatic int ciclo_fim(input logic [1:0] op, input int w);
    if (op < 2'd2) return 3;
    if (w >= T) return 2 + T;
    if (op == 2'd2) return 3 + ciclos_mem(op, w);
    return 2 + ciclos_mem(op, w);
  endfunction

  // Expected outputs on cycle k of a transaction, from the timeline rules
  function automatic saida_t modelo(input logic [1:0] op, input int w, input int k,
                                    input logic [5:0] fl_ant, input logic [5:0] fl);
    saida_t s;
    logic alu, tmo;
    int m, fim_c, wb_c;
    s     = '0;
    alu   = (op < 2'd2);
    tmo   = !alu && (w >= T);
    m     = ciclos_mem(op, w);
    fim_c = ciclo_fim(op, w);
    wb_c  = alu ? 2 : ((op == 2'd2 && !tmo) ? 2 + m : -1);
    if (k == 1) begin
      s.busy     = 1'b1;
      s.op_mem_i = alu ? 2'b00 : 2'b10;
      s.add_sub  = (op == 2'd1);
    end else if (!alu && k >= 2 && k < 2 + m) begin
      s.busy     = 1'b1;
      s.mem_req  = 1'b1;
      s.mem_we   = (op == 2'd3);
      s.op_mem_i = 2'b10;
    end else if (k == wb_c) begin
      s.busy     = 1'b1;
      s.rf_we    = 1'b1;
      s.rf_wsel  = (op == 2'd2);
      s.op_mem_i = alu ? 2'b00 : 2'b10;
      s.add_sub  = (op == 2'd1);
    end else if (k == fim_c) begin
      s.done = 1'b1;
      s.busy = tmo;
    end
    s.erro = tmo && (k >= fim_c);
`ifdef FLAGS_REG_EN
    s.flags = (alu && k >= 2) ? fl : fl_ant;
`else
    s.flags = 6'h00;
`endif
    return s;
  endfunction

  // One transaction starting on the current cycle, checked every cycle
  task automatic run_txn(input logic [1:0] op, input int w, input logic [5:0] fl,
                         output int done_c, output int nreq, output int nwe, output logic erro_fim);
    int fim_c, m;
    saida_t a, e;
    logic [5:0] fl_ant;
    fim_c    = ciclo_fim(op, w);
    m        = ciclos_mem(op, w);
    fl_ant   = flags_mod;
    start    = 1'b1;
    opcode   = op;
    flags_in = fl;
    mem_ack  = 1'($urandom_range(0, 1));
    done_c   = -1;
    nreq     = 0;
    nwe      = 0;
    a        = '0;
    e        = '0;
    for (int k = 1; k <= fim_c + 1; k++) begin
      @(negedge clk);
      a = atual_s();
      e = modelo(op, w, k, fl_ant, fl);
      verifica($sformatf("ciclo op=%0d w=%0d k=%0d", op, w, k), 32'(a), 32'(e));
      if (a.done && done_c < 0) done_c = k;
      nreq += int'(a.mem_req);
      nwe  += int'(a.rf_we);
      start  = (k <= fim_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode = 2'($urandom_range(0, 3));
      if (m > 0 && k >= 2 && k < 2 + m) mem_ack = (k == 2 + w);
      else mem_ack = 1'($urandom_range(0, 1));
    end
    erro_fim  = a.erro;
    erro_mod  = e.erro;
    flags_mod = e.flags;
  endtask

  vetor_t tab[8];
  int     dc, nr, nw;
  logic   ef;
  logic [5:0] fl_esp;

  initial begin
    tab[0] = '{op: 2'd0, w: 0,  fl: 6'h15, done_exp: 3, req_exp: 0, we_exp: 1, erro_exp: 1'b0};
    tab[1] = '{op: 2'd1, w: 0,  fl: 6'h2A, done_exp: 3, req_exp: 0, we_exp: 1, erro_exp: 1'b0};
    tab[2] = '{op: 2'd2, w: 2,  fl: 6'h0F, done_exp: 6, req_exp: 3, we_exp: 1, erro_exp: 1'b0};
    tab[3] = '{op: 2'd3, w: 99, fl: 6'h11, done_exp: 6, req_exp: 4, we_exp: 0, erro_exp: 1'b1};
    tab[4] = '{op: 2'd0, w: 0,  fl: 6'h33, done_exp: 3, req_exp: 0, we_exp: 1, erro_exp: 1'b0};
    tab[5] = '{op: 2'd3, w: 0,  fl: 6'h01, done_exp: 3, req_exp: 1, we_exp: 0, erro_exp: 1'b0};
    tab[6] = '{op: 2'd2, w: 3,  fl: 6'h3C, done_exp: 7, req_exp: 4, we_exp: 1, erro_exp: 1'b0};
    tab[7] = '{op: 2'd2, w: 0,  fl: 6'h07, done_exp: 4, req_exp: 1, we_exp: 1, erro_exp: 1'b0};

`ifdef FLAGS_REG_EN
    fl_esp = 6'h2A;
`else
    fl_esp = 6'h00;
`endif

    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = 2'b00;
    mem_ack   = 1'b0;
    flags_in  = 6'h00;
    erro_mod  = 1'b0;
    flags_mod = 6'h00;
    @(negedge clk);
    @(negedge clk);
    verifica("reset_state", 32'(atual_s()), 32'h0);
    rst_n = 1'b1;

    // Directed table; first row starts on the first edge after reset release
    for (int i = 0; i < 8; i++) begin
      run_txn(tab[i].op, tab[i].w, tab[i].fl, dc, nr, nw, ef);
      verifica($sformatf("tab%0d_done_cycle", i), 32'(dc), 32'(tab[i].done_exp));
      verifica($sformatf("tab%0d_mem_req_cycles", i), 32'(nr), 32'(tab[i].req_exp));
      verifica($sformatf("tab%0d_rf_we_cycles", i), 32'(nw), 32'(tab[i].we_exp));
      verifica($sformatf("tab%0d_erro", i), 32'(ef), 32'(tab[i].erro_exp));
      if (i == 1 || i == 2) verifica($sformatf("tab%0d_flags_q", i), 32'(flags_q), 32'(fl_esp));
    end

    // Start with opcode SUB while an ADD is busy must not alter the ADD
    start = 1'b1; opcode = 2'b00; mem_ack = 1'b0; flags_in = 6'h00;
    @(negedge clk);
    start = 1'b1; opcode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    verifica("ignored_start_add_sub", 32'(add_sub), 32'h0);
    verifica("ignored_start_rf_we", 32'(rf_we), 32'h1);
    @(negedge clk);
    verifica("ignored_start_done", 32'(done), 32'h1);
    @(negedge clk);
    verifica("ignored_start_idle", 32'(busy), 32'h0);
`ifdef FLAGS_REG_EN
    flags_mod = 6'h00;
`endif

    // Asynchronous reset in the middle of a memory wait
    start = 1'b1; opcode = 2'b10; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    verifica("mid_mem_req_before", 32'(mem_req), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    verifica("async_reset_mem_req", 32'(mem_req), 32'h0);
    verifica("async_reset_busy", 32'(busy), 32'h0);
    verifica("async_reset_all", 32'(atual_s()), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    erro_mod  = 1'b0;
    flags_mod = 6'h00;
    run_txn(2'd1, 0, 6'h2A, dc, nr, nw, ef);
    verifica("after_reset_done_cycle", 32'(dc), 32'd3);

    // Random transactions against the timeline model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op_r;
      int         w_r;
      op_r = 2'($urandom_range(0, 3));
      w_r  = int'($urandom_range(0, 6));
      run_txn(op_r, w_r, 6'($urandom), dc, nr, nw, ef);
      verifica($sformatf("rand%0d_done_cycle", i), 32'(dc), 32'(ciclo_fim(op_r, w_r)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
